// File: rtl/tdm_demux_1_4_if.sv
// Bundle between the TDM stream source and the 1:4 demultiplexer.
// The source drives din/din_valid/sync; the demux returns channels and status.
interface tdm_demux_1_4_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             sync;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic             frame_valid;
    logic             sync_err;
    logic             locked;

    modport master (
        output din, din_valid, sync,
        input  d0, d1, d2, d3, frame_valid, sync_err, locked
    );

    modport slave (
        input  din, din_valid, sync,
        output d0, d1, d2, d3, frame_valid, sync_err, locked
    );
endinterface

// File: rtl/tdm_demux_1_4.sv
// 1:4 TDM demultiplexer: frames of 4 slots marked by sync on slot 0,
// channel outputs reload together once per complete frame.
module tdm_demux_1_4 #(
    parameter int WIDTH = 3
) (
    input logic              clk,
    input logic              rst,
    tdm_demux_1_4_if.slave   bus
);
    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state, state_n;
    logic [1:0]       cnt, cnt_n;
    logic [WIDTH-1:0] sh0, sh1, sh2;
    logic [WIDTH-1:0] sh0_n, sh1_n, sh2_n;
    logic [WIDTH-1:0] d0, d1, d2, d3;
    logic [WIDTH-1:0] d0_n, d1_n, d2_n, d3_n;
    logic             fv, fv_n;
    logic             err, err_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
            cnt   <= '0;
            sh0   <= '0;
            sh1   <= '0;
            sh2   <= '0;
            d0    <= '0;
            d1    <= '0;
            d2    <= '0;
            d3    <= '0;
            fv    <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sh0   <= sh0_n;
            sh1   <= sh1_n;
            sh2   <= sh2_n;
            d0    <= d0_n;
            d1    <= d1_n;
            d2    <= d2_n;
            d3    <= d3_n;
            fv    <= fv_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh0_n   = sh0;
        sh1_n   = sh1;
        sh2_n   = sh2;
        d0_n    = d0;
        d1_n    = d1;
        d2_n    = d2;
        d3_n    = d3;
        fv_n    = 1'b0;
        err_n   = 1'b0;
        if (bus.din_valid) begin
            unique case (state)
                HUNT: begin
                    if (bus.sync) begin
                        sh0_n   = bus.din;
                        cnt_n   = 2'd1;
                        state_n = LOCKED;
                    end
                end
                LOCKED: begin
                    if (bus.sync) begin
                        // Early sync restarts the frame rather than dropping lock
                        err_n = (cnt != 2'd0);
                        sh0_n = bus.din;
                        cnt_n = 2'd1;
                    end else begin
                        unique case (cnt)
                            2'd0: begin
                                err_n   = 1'b1;
                                state_n = HUNT;
                            end
                            2'd1: begin
                                sh1_n = bus.din;
                                cnt_n = 2'd2;
                            end
                            2'd2: begin
                                sh2_n = bus.din;
                                cnt_n = 2'd3;
                            end
                            2'd3: begin
                                d0_n  = sh0;
                                d1_n  = sh1;
                                d2_n  = sh2;
                                d3_n  = bus.din;
                                fv_n  = 1'b1;
                                cnt_n = 2'd0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.d0          = d0;
    assign bus.d1          = d1;
    assign bus.d2          = d2;
    assign bus.d3          = d3;
    assign bus.frame_valid = fv;
    assign bus.sync_err    = err;
    assign bus.locked      = (state == LOCKED);
endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Self-checking bench for tdm_demux_1_4: directed table, hand sequences
// and random stream checked against a queue-based frame model.
module tb_tdm_demux_1_4;
    localparam int WIDTH = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    tdm_demux_1_4_if #(.WIDTH(WIDTH)) bus ();

    tdm_demux_1_4 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int v;
        int s;
        int din;
        int e0;
        int e1;
        int e2;
        int e3;
        int efv;
        int eerr;
        int elk;
    } vec_t;

    vec_t tbl[$];

    // model: partial frame as a queue, empty queue means slot 0 expected
    bit mlocked;
    int mq[$];
    int md[4];
    int mfv;
    int merr;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int e0, input int e1,
                             input int e2, input int e3, input int efv,
                             input int eerr, input int elk);
        chk({tag, ".d0"}, 32'(bus.d0), e0);
        chk({tag, ".d1"}, 32'(bus.d1), e1);
        chk({tag, ".d2"}, 32'(bus.d2), e2);
        chk({tag, ".d3"}, 32'(bus.d3), e3);
        chk({tag, ".frame_valid"}, 32'(bus.frame_valid), efv);
        chk({tag, ".sync_err"}, 32'(bus.sync_err), eerr);
        chk({tag, ".locked"}, 32'(bus.locked), elk);
    endtask

    task automatic model_reset();
        mlocked = 1'b0;
        mq.delete();
        for (int i = 0; i < 4; i++) md[i] = 0;
        mfv  = 0;
        merr = 0;
    endtask

    task automatic model_beat(input int v, input int s, input int din);
        mfv  = 0;
        merr = 0;
        if (v == 0) return;
        if (!mlocked) begin
            if (s != 0) begin
                mq.delete();
                mq.push_back(din);
                mlocked = 1'b1;
            end
        end else if (s != 0) begin
            merr = (mq.size() != 0) ? 1 : 0;
            mq.delete();
            mq.push_back(din);
        end else if (mq.size() == 0) begin
            merr    = 1;
            mlocked = 1'b0;
        end else begin
            mq.push_back(din);
            if (mq.size() == 4) begin
                for (int i = 0; i < 4; i++) md[i] = mq[i];
                mfv = 1;
                mq.delete();
            end
        end
    endtask

    task automatic check_model(input string tag);
        check_out(tag, md[0], md[1], md[2], md[3], mfv, merr, int'(mlocked));
    endtask

    task automatic step(input int v, input int s, input int din);
        @(negedge clk);
        bus.din_valid = v[0];
        bus.sync      = s[0];
        bus.din       = din[WIDTH-1:0];
        @(posedge clk);
        #1;
        model_beat(v, s, din);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.din_valid = 1'b0;
        bus.sync      = 1'b0;
        bus.din       = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic add(input int v, input int s, input int din,
                       input int e0, input int e1, input int e2,
                       input int e3, input int efv, input int eerr,
                       input int elk);
        vec_t t;
        t = '{v, s, din, e0, e1, e2, e3, efv, eerr, elk};
        tbl.push_back(t);
    endtask

    initial begin
        int want;
        int s;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.din_valid = 1'b0;
        bus.sync      = 1'b0;
        bus.din       = '0;
        model_reset();
        #2;
        check_out("reset", 0, 0, 0, 0, 0, 0, 0);

        // HUNT discards, first frame, resync, missing sync, relock
        add(1, 0, 6, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 6, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 2, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 4, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 6, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 2, 4, 6, 0, 1, 0, 1);
        add(0, 0, 0, 2, 4, 6, 0, 0, 0, 1);
        add(1, 1, 1, 2, 4, 6, 0, 0, 0, 1);
        add(1, 0, 2, 2, 4, 6, 0, 0, 0, 1);
        add(1, 0, 3, 2, 4, 6, 0, 0, 0, 1);
        add(1, 0, 4, 1, 2, 3, 4, 1, 0, 1);
        add(1, 1, 7, 1, 2, 3, 4, 0, 0, 1);
        add(1, 0, 7, 1, 2, 3, 4, 0, 0, 1);
        add(1, 1, 5, 1, 2, 3, 4, 0, 1, 1);
        add(1, 0, 6, 1, 2, 3, 4, 0, 0, 1);
        add(1, 0, 2, 1, 2, 3, 4, 0, 0, 1);
        add(1, 0, 3, 5, 6, 2, 3, 1, 0, 1);
        add(1, 0, 4, 5, 6, 2, 3, 0, 1, 0);
        add(0, 0, 0, 5, 6, 2, 3, 0, 0, 0);
        add(1, 1, 3, 5, 6, 2, 3, 0, 0, 1);

        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].s, tbl[i].din);
            check_out($sformatf("tbl%0d", i), tbl[i].e0, tbl[i].e1,
                      tbl[i].e2, tbl[i].e3, tbl[i].efv, tbl[i].eerr,
                      tbl[i].elk);
        end

        // frame 5,3,7,1 with two idle cycles between beats
        do_reset();
        begin
            int gd[4] = '{5, 3, 7, 1};
            for (int b = 0; b < 4; b++) begin
                step(1, (b == 0) ? 1 : 0, gd[b]);
                if (b < 3) check_out($sformatf("gap.b%0d", b), 0, 0, 0, 0, 0, 0, 1);
                else check_out("gap.done", 5, 3, 7, 1, 1, 0, 1);
                if (b < 3) begin
                    for (int g = 0; g < 2; g++) begin
                        step(0, 0, 0);
                        check_out($sformatf("gap.idle%0d_%0d", b, g),
                                  0, 0, 0, 0, 0, 0, 1);
                    end
                end
            end
            step(0, 0, 0);
            check_out("gap.after", 5, 3, 7, 1, 0, 0, 1);
        end

        // async reset between slot 2 and slot 3
        step(1, 1, 1);
        step(1, 0, 2);
        step(1, 0, 3);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check_out("arst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 4);
        check_out("arst.slot3", 0, 0, 0, 0, 0, 0, 0);

        // random stream, mostly well framed with occasional violations
        do_reset();
        for (int c = 0; c < 800; c++) begin
            want = (mq.size() == 0) ? 1 : 0;
            s    = want ^ (($urandom_range(0, 9) == 0) ? 1 : 0);
            step(($urandom_range(0, 3) != 0) ? 1 : 0, s,
                 int'($urandom_range(0, 7)));
            check_model($sformatf("rnd%0d", c));
            if (c == 400) begin
                do_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tdm_demux_1_4.md
Name: tdm_demux_1_4

Overview:
Receive-side counterpart of the 4:1 channel mux: takes a time-division-multiplexed stream of WIDTH-bit slots and returns each slot to its own output channel d0..d3.
- Frames are 4 slots, slot 0 first, marked by a sync strobe.
- A HUNT/LOCKED state machine and a 2-bit slot counter track the frame.
- Channel outputs update together once per complete frame, so downstream logic always sees a coherent frame.

Parameters:
WIDTH, 3, bit width of each slot and of each channel output

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
din  input  WIDTH  multiplexed slot data
din_valid  input  1  din/sync are sampled only when high; gaps of any length allowed
sync  input  1  qualified by din_valid; marks the current beat as slot 0
d0  output  WIDTH  channel 0 (slot 0), registered
d1  output  WIDTH  channel 1 (slot 1), registered
d2  output  WIDTH  channel 2 (slot 2), registered
d3  output  WIDTH  channel 3 (slot 3), registered
frame_valid  output  1  one-cycle pulse: d0..d3 were just loaded with a new frame
sync_err  output  1  one-cycle pulse: framing violation detected
locked  output  1  high while state is LOCKED

Behaviour:
Reset (async, rst=1):
- d0..d3 = 0, frame_valid = 0, sync_err = 0, locked = 0.
- State = HUNT, slot_cnt = 0, shadow registers sh0..sh2 = 0.
- Reset mid-frame discards any partial frame. d0..d3 go to 0.

Beats:
- A beat is a cycle with din_valid=1. Cycles with din_valid=0 change nothing.
- frame_valid and sync_err default to 0 every cycle. Each is high only in the cycle after the edge that sets it.

HUNT:
- Beat with sync=1: sh0<=din, slot_cnt<=1, go LOCKED.
- Beat with sync=0: discarded, no error.

LOCKED, on a beat:
- sync=1 and slot_cnt!=0 (early sync, resync):
  - sync_err<=1, partial frame dropped.
  - sh0<=din, slot_cnt<=1, stay LOCKED.
- sync=0 and slot_cnt==0 (missing sync):
  - sync_err<=1, beat discarded, go HUNT.
- sync=1 and slot_cnt==0: sh0<=din, slot_cnt<=1.
- sync=0 and slot_cnt==1 or 2: sh[slot_cnt]<=din, slot_cnt++.
- sync=0 and slot_cnt==3 (frame complete):
  - On the same edge: d0<=sh0, d1<=sh1, d2<=sh2, d3<=din.
  - frame_valid<=1, slot_cnt wraps to 0.
  - Latency: 0 cycles from the slot-3 sampling edge to outputs updated.

Output hold:
- d0..d3 hold their last complete frame until the next complete frame. They never show a partial frame.
- locked is a registered decode of state. It changes on the edge that changes state.

Arithmetic and frame rules:
- slot_cnt is 2 bits and wraps 3->0 naturally.
- No data arithmetic; all data paths are straight WIDTH-bit copies.
- Back-to-back frames at full rate: a sync beat may immediately follow slot 3. That gives frame_valid every 4th cycle.

Test Plan:
- Reset then 4 consecutive beats {sync=1,din=5},{0,3},{0,7},{0,1} -> after the 4th edge: d0=5 d1=3 d2=7 d3=1, frame_valid high exactly 1 cycle, locked=1 from the 1st edge, sync_err never high.
- Same frame with din_valid=0 gaps of 2 cycles between each beat -> identical outputs. frame_valid fires only after the 4th valid beat. d0..d3 hold 0 until then.
- Beats in HUNT with sync=0 (din=6,6) then the full frame 2,4,6,0 -> first two beats ignored, d0..d3=2,4,6,0, no sync_err.
- LOCKED: frame 1,2,3,4 completes; next beats {1,7},{0,7},{1,5},{0,6},{0,2},{0,3} -> sync_err pulse on the 3rd beat, d0..d3 stay 1,2,3,4 until the frame 5,6,2,3 completes, then update to 5,6,2,3.
- After a complete frame, beat {sync=0,din=4} -> sync_err pulse, locked=0, d0..d3 unchanged. A following sync beat relocks.
- Assert rst asynchronously between slot 2 and slot 3 (no clock edge) -> outputs 0 and locked=0 immediately. A subsequent slot-3 beat after release produces no frame_valid.
